spike_event_packer: RTL and testbench

Parametrised multi-channel spike timestamper and byte packer that replaces the fixed 16-instance timestamper, arbitration mux and width-converter chain in front of the UART transmitter. It detects selected edges on `N_CH` asynchronous pulse lines and stamps each with a shared free-running counter. Events are merged through a round-robin arbiter into a FIFO and emitted as MSB-first byte packets on an AXI-Stream master. The stream is sized for direct connection to `uart_tx`. Additions over the previous chain: per-channel enable, edge-mode selection, drop counting and packet framing (`tlast`).

---
 rtl/spike_event_packer.sv | 208 ++++++++++++++++++++
 tb/tb_spike_event_packer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_packer.sv
// Multi-channel spike timestamper: edge detect, pending latch, round-robin arbiter,
// event FIFO and MSB-first byte serializer on an AXI-Stream master.
module spike_event_packer #(
  parameter int unsigned N_CH       = 16,
  parameter int unsigned TS_WIDTH   = 28,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned EDGE_MODE  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CH-1:0]               pulse_i,
  input  logic [N_CH-1:0]               ch_en,
  output logic [7:0]                    m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [15:0]                   drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned ID_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PKT_BYTES = (ID_W + TS_WIDTH + 7) / 8;
  localparam int unsigned WORD_W    = 8 * PKT_BYTES;
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned IDX_W     = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam int unsigned CNT_W     = $clog2(N_CH + 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [N_CH-1:0]     sync1, sync2, prev, evt, pend, pend_d, pts_we;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] pts [N_CH];
  logic [ID_W-1:0]     rr_ptr, gnt_id;
  logic                gnt_valid;
  logic [CNT_W-1:0]    ndrop;
  logic [16:0]         drop_sum;
  logic [WORD_W-1:0]   mem [FIFO_DEPTH];
  logic [WORD_W-1:0]   wdata, rd_data;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                full, empty, pop;
  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   sreg_q, sreg_d;

  // Synchroniser, previous-value register and free-running timestamp
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      prev   <= '0;
      ts_cnt <= '0;
    end else begin
      sync1  <= pulse_i;
      sync2  <= sync1;
      prev   <= sync2;
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
    end
  end

  always_comb begin
    if (EDGE_MODE == 0)      evt = sync2 & ~prev;
    else if (EDGE_MODE == 1) evt = ~sync2 & prev;
    else                     evt = sync2 ^ prev;
    evt = evt & ch_en;
  end

  // Round-robin search starting at rr_ptr; stalls while the FIFO is full
  always_comb begin : arb
    int c;
    c         = 0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      c = int'(rr_ptr) + i;
      if (c >= int'(N_CH)) c = c - int'(N_CH);
      if (!gnt_valid && pend[c] && !full) begin
        gnt_valid = 1'b1;
        gnt_id    = ID_W'(c);
      end
    end
  end

  // A grant frees the slot, so a same-cycle event re-arms it instead of dropping
  always_comb begin : pend_logic
    logic gk;
    gk     = 1'b0;
    pend_d = pend;
    pts_we = '0;
    ndrop  = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      gk = gnt_valid && (gnt_id == ID_W'(k));
      if (gk) pend_d[k] = 1'b0;
      if (evt[k]) begin
        if (pend[k] && !gk) begin
          ndrop = ndrop + CNT_W'(1);
        end else begin
          pend_d[k] = 1'b1;
          pts_we[k] = 1'b1;
        end
      end
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + 17'(ndrop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      rr_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      pend     <= pend_d;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (gnt_valid) begin
        if (gnt_id == ID_W'(N_CH - 1)) rr_ptr <= '0;
        else                           rr_ptr <= gnt_id + ID_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(N_CH); k++) begin
      if (pts_we[k]) pts[k] <= ts_cnt;
    end
  end

  // Event FIFO
  assign wdata   = WORD_W'({gnt_id, pts[gnt_id]});
  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign fifo_level = count;

  always_ff @(posedge clk) begin
    if (gnt_valid) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (gnt_valid) wr_ptr <= wr_ptr + AW'(1);
      if (pop)       rd_ptr <= rd_ptr + AW'(1);
      unique case ({gnt_valid, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Serializer state and registered stream outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      sreg_q        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      sreg_q        <= sreg_d;
      m_axis_tvalid <= (state_d == SEND);
      m_axis_tdata  <= sreg_d[WORD_W-1 -: 8];
      m_axis_tlast  <= (state_d == SEND) && (idx_d == IDX_W'(PKT_BYTES - 1));
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sreg_d  = sreg_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sreg_d  = rd_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          if (idx_q == IDX_W'(PKT_BYTES - 1)) begin
            if (!empty) begin
              pop    = 1'b1;
              sreg_d = rd_data;
              idx_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            sreg_d = sreg_q << 8;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spike_event_packer.sv
// Directed self-checking bench: default 16-channel build plus a 4-channel,
// 8-bit-timestamp, both-edge build for wrap and 2-byte packet cases.
module tb_spike_event_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pulse, ch_en;
  logic        tready;
  logic [7:0]  tdata;
  logic        tvalid, tlast;
  logic [15:0] drop_cnt;
  logic [4:0]  level;

  logic [3:0]  pulse2, ch_en2;
  logic        tready2;
  logic [7:0]  tdata2;
  logic        tvalid2, tlast2;
  logic [15:0] drop2;
  logic [2:0]  level2;

  logic [27:0] tb_ts;
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  // Reference copy of the free-running timestamp counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 28'd1;
  end

  spike_event_packer u_dut (
    .clk(clk), .rst(rst), .pulse_i(pulse), .ch_en(ch_en),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .drop_cnt(drop_cnt), .fifo_level(level)
  );

  spike_event_packer #(.N_CH(4), .TS_WIDTH(8), .FIFO_DEPTH(4), .EDGE_MODE(2)) u_dut2 (
    .clk(clk), .rst(rst), .pulse_i(pulse2), .ch_en(ch_en2),
    .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(tready2),
    .m_axis_tlast(tlast2), .drop_cnt(drop2), .fifo_level(level2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pkt(input logic [31:0] w, output int waited);
    waited = 0;
    while (tvalid !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    for (int b = 0; b < 4; b++) begin
      logic [31:0] sh;
      sh = w >> (8 * (3 - b));
      check("pkt_valid", 32'(tvalid), 32'd1);
      check("pkt_byte", 32'(tdata), 32'(sh[7:0]));
      check("pkt_last", 32'(tlast), 32'(b == 3));
      @(negedge clk);
    end
  endtask

  task automatic expect_pkt2(input logic [15:0] w);
    int waited;
    waited = 0;
    while (tvalid2 !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    check("pkt2_valid", 32'(tvalid2), 32'd1);
    check("pkt2_byte0", 32'(tdata2), 32'(w[15:8]));
    check("pkt2_last0", 32'(tlast2), 32'd0);
    @(negedge clk);
    check("pkt2_byte1", 32'(tdata2), 32'(w[7:0]));
    check("pkt2_last1", 32'(tlast2), 32'd1);
    @(negedge clk);
  endtask

  task automatic idle_watch(input int n, output int hits);
    hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (tvalid !== 1'b0) hits++;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
  endtask

  initial begin
    logic [27:0] ts, tsa, tsb;
    logic [7:0]  ts8;
    int w, hits, guard;

    rst = 1'b1; pulse = '0; ch_en = 16'hFFFF; tready = 1'b1;
    pulse2 = '0; ch_en2 = 4'hF; tready2 = 1'b1;
    step(2);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_tvalid2", 32'(tvalid2), 32'd0);
    rst = 1'b0;

    // Channel 3 rising edge detected at counter 0x100
    guard = 0;
    while (tb_ts != 28'hFE && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    pulse[3] = 1'b1;
    step(4);
    check("lat_d2_tvalid", 32'(tvalid), 32'd0);
    step(1);
    check("lat_d3_tvalid", 32'(tvalid), 32'd1);
    expect_pkt(32'h3000_0100, w);
    pulse = '0;
    step(3);

    // Simultaneous edges on 0, 5, 15 from rr_ptr 0, then 0 and 5 again
    pulse_rst();
    ts = tb_ts + 28'd2;
    pulse = 16'h8021;
    expect_pkt({4'd0, ts}, w);
    expect_pkt({4'd5, ts}, w);
    check("b2b_gap_5", 32'(w), 32'd0);
    expect_pkt({4'd15, ts}, w);
    check("b2b_gap_15", 32'(w), 32'd0);
    pulse = '0;
    step(3);
    ts = tb_ts + 28'd2;
    pulse = 16'h0021;
    expect_pkt({4'd0, ts}, w);
    expect_pkt({4'd5, ts}, w);
    check("rr_gap_5", 32'(w), 32'd0);
    pulse = '0;
    step(3);

    // Back-pressure: fill FIFO, hold in pend, count drops, then drain
    pulse_rst();
    tready = 1'b0;
    tsa = tb_ts + 28'd2;
    pulse = 16'hFFFF;
    step(3);
    pulse = '0;
    step(25);
    check("bp_level_a", 32'(level), 32'd15);
    check("bp_stall_valid", 32'(tvalid), 32'd1);
    check("bp_stall_byte", 32'(tdata), 32'({4'd0, tsa[27:24]}));
    tsb = tb_ts + 28'd2;
    pulse = 16'hFFFF;
    step(3);
    pulse = '0;
    step(10);
    check("bp_level_full", 32'(level), 32'd16);
    check("bp_drop0", 32'(drop_cnt), 32'd0);
    pulse = 16'h0020;
    step(3);
    pulse = '0;
    step(4);
    check("bp_drop1", 32'(drop_cnt), 32'd1);
    pulse = 16'hFE00;
    step(3);
    pulse = '0;
    step(4);
    check("bp_drop8", 32'(drop_cnt), 32'd8);
    check("bp_level_hold", 32'(level), 32'd16);
    tready = 1'b1;
    for (int k = 0; k < 16; k++) expect_pkt({4'(k), tsa}, w);
    expect_pkt({4'd0, tsb}, w);
    for (int k = 1; k < 16; k++) expect_pkt({4'(k), tsb}, w);
    step(3);
    check("bp_drained_level", 32'(level), 32'd0);
    check("bp_drained_valid", 32'(tvalid), 32'd0);
    check("bp_drop_keep", 32'(drop_cnt), 32'd8);

    // Disabled channel produces nothing
    ch_en = 16'hFFFB;
    hits = 0;
    for (int r = 0; r < 3; r++) begin
      pulse[2] = 1'b1;
      idle_watch(3, w);
      hits += w;
      pulse[2] = 1'b0;
      idle_watch(3, w);
      hits += w;
    end
    idle_watch(8, w);
    hits += w;
    check("chen_no_valid", 32'(hits), 32'd0);
    check("chen_level", 32'(level), 32'd0);
    ch_en = 16'hFFFF;

    // Reset mid-packet discards the remainder
    ts = tb_ts + 28'd2;
    pulse[1] = 1'b1;
    guard = 0;
    while (tvalid !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check("mid_b0", 32'(tdata), 32'({4'd1, ts[27:24]}));
    step(1);
    check("mid_b1", 32'(tdata), 32'(ts[23:16]));
    rst = 1'b1;
    pulse = '0;
    #1;
    check("mid_rst_tvalid", 32'(tvalid), 32'd0);
    check("mid_rst_tlast", 32'(tlast), 32'd0);
    check("mid_rst_tdata", 32'(tdata), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_watch(20, hits);
    check("mid_no_remnant", 32'(hits), 32'd0);
    check("mid_level", 32'(level), 32'd0);

    // Both-edge build: one pulse of 5 clocks gives two stamps 5 apart
    ts8 = tb_ts[7:0] + 8'd2;
    pulse2 = 4'b0100;
    step(5);
    pulse2 = '0;
    expect_pkt2({6'd0, 2'd2, ts8});
    expect_pkt2({6'd0, 2'd2, ts8 + 8'd5});

    // 8-bit counter wrap: stamps 0xFF then 0x01
    guard = 0;
    while (tb_ts[7:0] != 8'hFD && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    pulse2 = 4'b0010;
    step(2);
    pulse2 = '0;
    expect_pkt2(16'h01FF);
    expect_pkt2(16'h0101);
    check("wrap_drop2", 32'(drop2), 32'd0);
    check("wrap_level2", 32'(level2), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
